gen_imp_mc: RTL

Multi-channel, parametrised pulse generator, successor to the single-channel `Gen_IMP`. Each of `CH` independent channels produces a pulse train with a programmable period and high-time, counted in ticks of the shared `ce1us` clock enable. Channels run either continuously or as a triggered one-shot, and flag each end of period. The block sits beside the 1 µs timebase and feeds actuator and strobe logic.

---
 rtl/gen_imp_pkg.sv | 15 +
 rtl/gen_imp_ch.sv | 134 +++++++++++++
 rtl/gen_imp_mc.sv | 42 ++++
 3 files changed

// File: rtl/gen_imp_pkg.sv
// gen_imp_pkg: shared types and constants for the multi-channel pulse generator.
// Channel FSM states, per-channel mode encoding and the default field width.
package gen_imp_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam int W_DEF = 16;

endpackage

// File: rtl/gen_imp_ch.sv
// gen_imp_ch: one pulse-generator channel (FSM, tick counter, optional shadow regs).
// Optional feature: define GEN_IMP_LATCH_EN to capture period/high-time into
// shadow registers on RUN entry and on every wrap; otherwise live values are used.
module gen_imp_ch
    import gen_imp_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce1us,
    input  logic [W-1:0] per,
    input  logic [W-1:0] wid,
    input  logic         mode,
    input  logic         en,
    input  logic         trig,
    output logic         imp,
    output logic         busy,
    output logic         eop
);

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_cnt;
    logic [W-1:0]   w_cnt_next;
    logic           r_imp;
    logic           r_eop;
    logic           w_imp_next;
    logic           w_eop_next;
    logic [W-1:0]   w_per_eff;      // period governing the current cycle
    logic [W-1:0]   w_per_nx;       // period/high-time after this edge
    logic [W-1:0]   w_wid_nx;
    logic [W-1:0]   w_hi_len;       // min(H, P) of the next period
    logic           w_stop_live;    // live period dropped to zero

`ifdef GEN_IMP_LATCH_EN
    logic [W-1:0]   r_per_sh;
    logic [W-1:0]   r_wid_sh;
    logic           w_capture;

    // Reload on RUN entry and at every period boundary.
    assign w_capture   = w_eop_next || ((r_state == ST_IDLE) && (w_state_next == ST_RUN));
    assign w_per_eff   = r_per_sh;
    assign w_per_nx    = w_capture ? per : r_per_sh;
    assign w_wid_nx    = w_capture ? wid : r_wid_sh;
    assign w_stop_live = 1'b0;

    // Shadow registers for period and high-time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_sh <= '0;
            r_wid_sh <= '0;
        end else if (w_capture) begin
            r_per_sh <= per;
            r_wid_sh <= wid;
        end
    end
`else
    assign w_per_eff   = per;
    assign w_per_nx    = per;
    assign w_wid_nx    = wid;
    assign w_stop_live = (per == '0);
`endif

    assign w_hi_len = (w_wid_nx < w_per_nx) ? w_wid_nx : w_per_nx;

    // Next-state, counter and strobe logic; en=0 overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_eop_next   = 1'b0;
        if (!en) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((per != '0) && ((mode == MODE_CONT) || trig)) begin
                        w_state_next = ST_RUN;
                        w_cnt_next   = '0;
                    end
                end
                ST_RUN: begin
                    if (w_stop_live) begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end else if (ce1us) begin
                        // >= rather than == so a lowered period still terminates.
                        if (r_cnt >= (w_per_eff - W'(1))) begin
                            w_cnt_next = '0;
                            w_eop_next = 1'b1;
                            if (mode == MODE_ONESHOT) begin
                                w_state_next = ST_IDLE;
                            end
`ifdef GEN_IMP_LATCH_EN
                            // A zero period only takes effect at the boundary.
                            if (per == '0) begin
                                w_state_next = ST_IDLE;
                            end
`endif
                        end else begin
                            w_cnt_next = r_cnt + W'(1);
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
        w_imp_next = (w_state_next == ST_RUN) && (w_cnt_next < w_hi_len);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_imp   <= 1'b0;
            r_eop   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_imp   <= w_imp_next;
            r_eop   <= w_eop_next;
        end
    end

    assign imp  = r_imp;
    assign eop  = r_eop;
    assign busy = (r_state == ST_RUN);

endmodule

// File: rtl/gen_imp_mc.sv
// gen_imp_mc: CH independent pulse-generator channels sharing the 1 us tick.
// Optional feature: GEN_IMP_LATCH_EN (see gen_imp_ch) selects latched parameters.
module gen_imp_mc
    import gen_imp_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce1us,
    input  logic [CH*W-1:0] per,
    input  logic [CH*W-1:0] wid,
    input  logic [CH-1:0]   mode,
    input  logic [CH-1:0]   en,
    input  logic [CH-1:0]   trig,
    output logic [CH-1:0]   imp,
    output logic [CH-1:0]   busy,
    output logic [CH-1:0]   eop
);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            gen_imp_ch #(
                .W(W)
            ) u_ch (
                .clk  (clk),
                .rst  (rst),
                .ce1us(ce1us),
                .per  (per[gi*W +: W]),
                .wid  (wid[gi*W +: W]),
                .mode (mode[gi]),
                .en   (en[gi]),
                .trig (trig[gi]),
                .imp  (imp[gi]),
                .busy (busy[gi]),
                .eop  (eop[gi])
            );
        end
    endgenerate

endmodule
